tlb_op_ctrl: RTL and testbench

Multi-cycle sequencer for the MIPS TLB-management instructions (TLBR, TLBWI, TLBWR, TLBP). It sits between the decode/execute stage, the CP0 register file and the 16-entry TLB array. It holds the pipeline via `busy_o` while it moves data between the CP0 Index/Random/EntryHi/EntryLo registers and the TLB array. TLBP is a pipelined sequential scan that reports the lowest matching index or a probe failure.

---
 rtl/tlb_op_ctrl_pkg.sv | 37 +++
 rtl/tlb_op_ctrl_entry_match.sv | 26 ++
 rtl/tlb_op_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_op_ctrl_pkg.sv
// Shared CPU constants for the TLB-management sequencer and the MMU lookup path:
// op-codes, sequencer state encodings and EntryHi field positions.
package tlb_op_ctrl_pkg;

    localparam logic [1:0] TLBOP_TLBR  = 2'd0;
    localparam logic [1:0] TLBOP_TLBWI = 2'd1;
    localparam logic [1:0] TLBOP_TLBWR = 2'd2;
    localparam logic [1:0] TLBOP_TLBP  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TLBR_ADDR = 3'd1,
        ST_TLBR_CAP  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_PROBE     = 3'd4,
        ST_DONE      = 3'd5
    } tlb_state_e;

    localparam int EHI_VPN2_HI = 31;
    localparam int EHI_VPN2_LO = 13;
    localparam int EHI_ASID_HI = 7;
    localparam int EHI_ASID_LO = 0;
    localparam int VPN2_W      = 19;
    localparam int ASID_W      = 8;
    localparam int TLB_HI_W    = VPN2_W + ASID_W;
    localparam int ENTRYLO_W   = 26;

    // The TLB stores {VPN2, ASID}; EntryHi bits [12:8] read back as zero.
    function automatic logic [TLB_HI_W-1:0] ehi_to_tlb(input logic [31:0] ehi);
        return {ehi[EHI_VPN2_HI:EHI_VPN2_LO], ehi[EHI_ASID_HI:EHI_ASID_LO]};
    endfunction

    function automatic logic [31:0] tlb_to_ehi(input logic [TLB_HI_W-1:0] hi);
        return {hi[TLB_HI_W-1:ASID_W], 5'b0_0000, hi[ASID_W-1:0]};
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_entry_match.sv
// Combinational TLB entry comparison: VPN2 must match, and either the entry is
// global (both G bits set) or its ASID matches.
module tlb_entry_match
    import tlb_op_ctrl_pkg::*;
(
    input  logic [TLB_HI_W-1:0] entry_hi,
    input  logic                entry_g0,
    input  logic                entry_g1,
    input  logic [VPN2_W-1:0]   vpn2,
    input  logic [ASID_W-1:0]   asid,
    output logic                hit
);

    logic vpn2_eq_s;
    logic asid_eq_s;
    logic global_s;

    // Field compare and hit combine
    always_comb begin
        vpn2_eq_s = (entry_hi[TLB_HI_W-1:ASID_W] == vpn2);
        asid_eq_s = (entry_hi[ASID_W-1:0] == asid);
        global_s  = entry_g0 & entry_g1;
        hit       = vpn2_eq_s & (global_s | asid_eq_s);
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Multi-cycle sequencer for TLBR/TLBWI/TLBWR/TLBP: moves data between the CP0
// snapshot and the TLB array while holding the pipeline through busy_o.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid_i,
    input  logic [1:0]           op_code_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic [IDX_W-1:0]     cp0_index_i,
    input  logic [IDX_W-1:0]     cp0_random_i,
    input  logic [31:0]          cp0_entryhi_i,
    input  logic [ENTRYLO_W-1:0] cp0_entrylo0_i,
    input  logic [ENTRYLO_W-1:0] cp0_entrylo1_i,
    output logic [IDX_W-1:0]     tlb_addr_o,
    output logic                 tlb_we_o,
    output logic [TLB_HI_W-1:0]  tlb_whi_o,
    output logic [ENTRYLO_W-1:0] tlb_wlo0_o,
    output logic [ENTRYLO_W-1:0] tlb_wlo1_o,
    input  logic [TLB_HI_W-1:0]  tlb_rhi_i,
    input  logic [ENTRYLO_W-1:0] tlb_rlo0_i,
    input  logic [ENTRYLO_W-1:0] tlb_rlo1_i,
    output logic [31:0]          cp0_entryhi_o,
    output logic                 cp0_entryhi_wen_o,
    output logic [ENTRYLO_W-1:0] cp0_entrylo0_o,
    output logic                 cp0_entrylo0_wen_o,
    output logic [ENTRYLO_W-1:0] cp0_entrylo1_o,
    output logic                 cp0_entrylo1_wen_o,
    output logic [IDX_W-1:0]     cp0_index_o,
    output logic                 cp0_index_wen_o,
    output logic                 probe_fail_o
);

    localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(ENTRIES);
    localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1'b1);
    localparam logic [IDX_W:0] CNT_ZERO = {(IDX_W+1){1'b0}};

    tlb_state_e           state_r;
    tlb_state_e           state_next_s;
    logic [IDX_W:0]       cnt_r;
    logic [IDX_W:0]       cnt_next_s;
    logic [IDX_W:0]       cnt_m1_s;
    logic [1:0]           op_r;
    logic [TLB_HI_W-1:0]  ehi_r;
    logic [ENTRYLO_W-1:0] lo0_r;
    logic [ENTRYLO_W-1:0] lo1_r;
    logic [IDX_W-1:0]     index_r;
    logic [IDX_W-1:0]     random_r;
    logic                 accept_s;
    logic                 probe_hit_s;
    logic                 tlb_we_s;
    logic                 ehi_wen_s;
    logic                 lo0_wen_s;
    logic                 lo1_wen_s;
    logic                 index_wen_s;
    logic                 done_s;

    assign accept_s = (state_r == ST_IDLE) && op_valid_i;
    assign cnt_m1_s = cnt_r - CNT_ONE;

    tlb_entry_match u_match (
        .entry_hi (tlb_rhi_i),
        .entry_g0 (tlb_rlo0_i[0]),
        .entry_g1 (tlb_rlo1_i[0]),
        .vpn2     (ehi_r[TLB_HI_W-1:ASID_W]),
        .asid     (ehi_r[ASID_W-1:0]),
        .hit      (probe_hit_s)
    );

    // State, probe counter and the request snapshot taken at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            op_r     <= 2'd0;
            ehi_r    <= {TLB_HI_W{1'b0}};
            lo0_r    <= {ENTRYLO_W{1'b0}};
            lo1_r    <= {ENTRYLO_W{1'b0}};
            index_r  <= {IDX_W{1'b0}};
            random_r <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (accept_s) begin
                op_r     <= op_code_i;
                ehi_r    <= ehi_to_tlb(cp0_entryhi_i);
                lo0_r    <= cp0_entrylo0_i;
                lo1_r    <= cp0_entrylo1_i;
                index_r  <= cp0_index_i;
                random_r <= cp0_random_i;
            end
        end
    end

    // Next-state and Moore-style output decode
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        tlb_addr_o     = {IDX_W{1'b0}};
        tlb_whi_o      = {TLB_HI_W{1'b0}};
        tlb_wlo0_o     = {ENTRYLO_W{1'b0}};
        tlb_wlo1_o     = {ENTRYLO_W{1'b0}};
        cp0_entryhi_o  = 32'h0000_0000;
        cp0_entrylo0_o = {ENTRYLO_W{1'b0}};
        cp0_entrylo1_o = {ENTRYLO_W{1'b0}};
        cp0_index_o    = {IDX_W{1'b0}};
        probe_fail_o   = 1'b0;
        tlb_we_s       = 1'b0;
        ehi_wen_s      = 1'b0;
        lo0_wen_s      = 1'b0;
        lo1_wen_s      = 1'b0;
        index_wen_s    = 1'b0;
        done_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_valid_i) begin
                    cnt_next_s = CNT_ZERO;
                    case (op_code_i)
                        TLBOP_TLBR:               state_next_s = ST_TLBR_ADDR;
                        TLBOP_TLBWI, TLBOP_TLBWR: state_next_s = ST_WRITE;
                        TLBOP_TLBP:               state_next_s = ST_PROBE;
                        default:                  state_next_s = ST_IDLE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_TLBR_ADDR: begin
                tlb_addr_o   = index_r;
                state_next_s = ST_TLBR_CAP;
            end
            ST_TLBR_CAP: begin
                ehi_wen_s      = 1'b1;
                lo0_wen_s      = 1'b1;
                lo1_wen_s      = 1'b1;
                cp0_entryhi_o  = tlb_to_ehi(tlb_rhi_i);
                cp0_entrylo0_o = tlb_rlo0_i;
                cp0_entrylo1_o = tlb_rlo1_i;
                state_next_s   = ST_DONE;
            end
            ST_WRITE: begin
                tlb_we_s     = 1'b1;
                tlb_addr_o   = (op_r == TLBOP_TLBWR) ? random_r : index_r;
                tlb_whi_o    = ehi_r;
                tlb_wlo0_o   = lo0_r;
                tlb_wlo1_o   = lo1_r;
                state_next_s = ST_DONE;
            end
            ST_PROBE: begin
                // Read data lags the address by one cycle, so cnt compares entry cnt-1
                tlb_addr_o = cnt_r[IDX_W-1:0];
                if ((cnt_r != CNT_ZERO) && probe_hit_s) begin
                    index_wen_s  = 1'b1;
                    cp0_index_o  = cnt_m1_s[IDX_W-1:0];
                    probe_fail_o = 1'b0;
                    state_next_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    index_wen_s  = 1'b1;
                    cp0_index_o  = index_r;
                    probe_fail_o = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                done_s       = 1'b1;
                cnt_next_s   = CNT_ZERO;
                state_next_s = ST_IDLE;
            end
            default: begin
                cnt_next_s   = CNT_ZERO;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Strobes are suppressed combinationally so a reset cycle never commits anything
    assign tlb_we_o           = tlb_we_s    & ~reset;
    assign cp0_entryhi_wen_o  = ehi_wen_s   & ~reset;
    assign cp0_entrylo0_wen_o = lo0_wen_s   & ~reset;
    assign cp0_entrylo1_wen_o = lo1_wen_s   & ~reset;
    assign cp0_index_wen_o    = index_wen_s & ~reset;
    assign done_o             = done_s      & ~reset;
    assign busy_o             = (state_r != ST_IDLE);

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small synchronous-read TLB array model.
module tb_tlb_op_ctrl;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op_code;
    logic        busy;
    logic        done;
    logic [3:0]  cp0_index;
    logic [3:0]  cp0_random;
    logic [31:0] cp0_entryhi;
    logic [25:0] cp0_entrylo0;
    logic [25:0] cp0_entrylo1;
    logic [3:0]  tlb_addr;
    logic        tlb_we;
    logic [26:0] tlb_whi;
    logic [25:0] tlb_wlo0;
    logic [25:0] tlb_wlo1;
    logic [26:0] tlb_rhi;
    logic [25:0] tlb_rlo0;
    logic [25:0] tlb_rlo1;
    logic [31:0] ehi_out;
    logic        ehi_wen;
    logic [25:0] lo0_out;
    logic        lo0_wen;
    logic [25:0] lo1_out;
    logic        lo1_wen;
    logic [3:0]  index_out;
    logic        index_wen;
    logic        probe_fail;

    logic [26:0] mem_hi  [0:15];
    logic [25:0] mem_lo0 [0:15];
    logic [25:0] mem_lo1 [0:15];

    int n_asserts;
    int n_fail;
    int busy_cnt;

    tlb_op_ctrl #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .op_valid_i         (op_valid),
        .op_code_i          (op_code),
        .busy_o             (busy),
        .done_o             (done),
        .cp0_index_i        (cp0_index),
        .cp0_random_i       (cp0_random),
        .cp0_entryhi_i      (cp0_entryhi),
        .cp0_entrylo0_i     (cp0_entrylo0),
        .cp0_entrylo1_i     (cp0_entrylo1),
        .tlb_addr_o         (tlb_addr),
        .tlb_we_o           (tlb_we),
        .tlb_whi_o          (tlb_whi),
        .tlb_wlo0_o         (tlb_wlo0),
        .tlb_wlo1_o         (tlb_wlo1),
        .tlb_rhi_i          (tlb_rhi),
        .tlb_rlo0_i         (tlb_rlo0),
        .tlb_rlo1_i         (tlb_rlo1),
        .cp0_entryhi_o      (ehi_out),
        .cp0_entryhi_wen_o  (ehi_wen),
        .cp0_entrylo0_o     (lo0_out),
        .cp0_entrylo0_wen_o (lo0_wen),
        .cp0_entrylo1_o     (lo1_out),
        .cp0_entrylo1_wen_o (lo1_wen),
        .cp0_index_o        (index_out),
        .cp0_index_wen_o    (index_wen),
        .probe_fail_o       (probe_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read TLB array: data appears the cycle after the address
    always @(posedge clk) begin
        tlb_rhi  <= mem_hi[tlb_addr];
        tlb_rlo0 <= mem_lo0[tlb_addr];
        tlb_rlo1 <= mem_lo1[tlb_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op);
        op_code  = op;
        op_valid = 1'b1;
        step();
        op_valid = 1'b0;
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        reset = 1'b1; op_valid = 1'b0; op_code = 2'd0;
        cp0_index = 4'd0; cp0_random = 4'd0; cp0_entryhi = 32'h0;
        cp0_entrylo0 = 26'h0; cp0_entrylo1 = 26'h0;
        for (int i = 0; i < 16; i++) begin
            mem_hi[i]  = {19'h10000 + 19'(i), 8'h00};
            mem_lo0[i] = 26'(i) << 1;
            mem_lo1[i] = 26'(i) << 1;
        end
        mem_hi[5]  = {19'h12345, 8'h21}; mem_lo0[5]  = 26'h0ABCDE0; mem_lo1[5]  = 26'h0ABCDF0;
        mem_hi[2]  = {19'h00400, 8'h07}; mem_lo0[2]  = 26'h0000000; mem_lo1[2]  = 26'h0000000;
        mem_hi[11] = {19'h00400, 8'h00}; mem_lo0[11] = 26'h0000001; mem_lo1[11] = 26'h0000001;

        // Reset state
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", tlb_addr, 4'd0);
        chk("rst_we", tlb_we, 1'b0);
        chk("rst_whi", tlb_whi, 27'h0);
        chk("rst_wens", {ehi_wen, lo0_wen, lo1_wen, index_wen}, 4'b0000);
        chk("rst_ehi", ehi_out, 32'h0);
        chk("rst_idx", {probe_fail, index_out}, 5'h00);
        reset = 1'b0;

        // TLBR of entry 5
        cp0_index = 4'd5;
        issue(2'd0);
        chk("tlbr_busy1", busy, 1'b1);
        chk("tlbr_addr", tlb_addr, 4'd5);
        chk("tlbr_wen1", ehi_wen, 1'b0);
        step();
        chk("tlbr_wens", {ehi_wen, lo0_wen, lo1_wen}, 3'b111);
        chk("tlbr_ehi", ehi_out, 32'h2468A021);
        chk("tlbr_lo0", lo0_out, 26'h0ABCDE0);
        chk("tlbr_lo1", lo1_out, 26'h0ABCDF0);
        chk("tlbr_done2", done, 1'b0);
        step();
        chk("tlbr_done3", done, 1'b1);
        chk("tlbr_wens3", {ehi_wen, lo0_wen, lo1_wen}, 3'b000);
        step();
        chk("tlbr_idle", busy, 1'b0);

        // TLBWI at Index 3; inputs scrambled after accept to prove the snapshot
        cp0_index = 4'd3; cp0_random = 4'd12; cp0_entryhi = 32'h2468A021;
        cp0_entrylo0 = 26'h1555555; cp0_entrylo1 = 26'h2AAAAAA;
        issue(2'd1);
        cp0_index = 4'd15; cp0_entryhi = 32'hFFFFFFFF; cp0_entrylo0 = 26'h3FFFFFF; cp0_entrylo1 = 26'h0;
        #1;
        chk("wi_we", tlb_we, 1'b1);
        chk("wi_addr", tlb_addr, 4'd3);
        chk("wi_whi", tlb_whi, 27'h1234521);
        chk("wi_wlo0", tlb_wlo0, 26'h1555555);
        chk("wi_wlo1", tlb_wlo1, 26'h2AAAAAA);
        step();
        chk("wi_done", done, 1'b1);
        chk("wi_we2", tlb_we, 1'b0);
        cp0_index = 4'd3; cp0_random = 4'd9; cp0_entryhi = 32'h00800007;
        cp0_entrylo0 = 26'h0000001; cp0_entrylo1 = 26'h3FFFFFF;
        step();
        chk("wi_idle", busy, 1'b0);

        // TLBWR at Random 9, accepted back-to-back in the IDLE cycle after DONE
        issue(2'd2);
        chk("wr_we", tlb_we, 1'b1);
        chk("wr_addr", tlb_addr, 4'd9);
        chk("wr_whi", tlb_whi, 27'h0040007);
        chk("wr_wlo", {tlb_wlo0, tlb_wlo1}, {26'h0000001, 26'h3FFFFFF});
        step();
        chk("wr_done", done, 1'b1);
        chk("wr_we2", tlb_we, 1'b0);
        step();

        // TLBP: entries 2 and 11 match, lowest wins; a TLBWI pulse while busy is ignored
        cp0_index = 4'd9; cp0_entryhi = 32'h00800007;
        issue(2'd3);
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) begin
                op_code = 2'd1; op_valid = 1'b1;
            end else begin
                op_valid = 1'b0;
            end
            #1;
            chk("pm_busy", busy, (c <= 5));
            chk("pm_done", done, (c == 5));
            chk("pm_iwen", index_wen, (c == 4));
            chk("pm_we", tlb_we, 1'b0);
            if (c == 4) begin
                chk("pm_index", index_out, 4'd2);
                chk("pm_fail", probe_fail, 1'b0);
            end
            step();
        end
        op_valid = 1'b0;

        // TLBP with no match: 17 probe cycles plus DONE
        cp0_index = 4'd6; cp0_entryhi = 32'hAAAAA033;
        issue(2'd3);
        busy_cnt = 0;
        for (int c = 1; c <= 19; c++) begin
            if (busy) busy_cnt++;
            chk("pf_iwen", index_wen, (c == 17));
            chk("pf_done", done, (c == 18));
            if (c == 17) begin
                chk("pf_index", index_out, 4'd6);
                chk("pf_fail", probe_fail, 1'b1);
            end
            step();
        end
        chk("pf_busy_cycles", busy_cnt, 32'd18);

        // Reset during the 8th probe cycle aborts the scan
        issue(2'd3);
        for (int c = 1; c < 8; c++) step();
        reset = 1'b1;
        #1;
        chk("pr_iwen", index_wen, 1'b0);
        chk("pr_done", done, 1'b0);
        chk("pr_busy", busy, 1'b1);
        step();
        chk("pr_idle", busy, 1'b0);
        chk("pr_outs", {tlb_addr, tlb_we, done, index_wen, index_out, probe_fail}, 12'h000);
        chk("pr_ehi", ehi_out, 32'h0);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("pr_quiet", {done, index_wen, busy}, 3'b000);
        end

        // Reset during WRITE masks the write strobe combinationally
        cp0_index = 4'd4;
        issue(2'd1);
        reset = 1'b1;
        #1;
        chk("wrst_we", tlb_we, 1'b0);
        step();
        reset = 1'b0;
        chk("wrst_idle", busy, 1'b0);
        step();
        chk("wrst_done", done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
